async_down_counter_nbit: RTL and testbench

Parameterised n-bit asynchronous (ripple) down counter. It is the counting-direction counterpart of the team's ripple up counter. Bit 0 toggles on the system clock, and each higher bit is clocked by the bit below it. A clock-domain snapshot of the count and a wrap (terminal-count) strobe are registered on `clk`, so synchronous logic can consume the ripple value safely. It is used as a prescaler and countdown source in the counters library.

---
 rtl/async_down_counter_nbit.sv | 41 ++++
 tb/tb_async_down_counter_nbit.sv | 93 +++++++++
 2 files changed

// File: rtl/async_down_counter_nbit.sv
// async_down_counter_nbit: n-bit ripple down counter, each stage clocked by the rising edge of the one below.
// Define ASYNC_DOWN_COUNTER_SYNC_OUT_EN to add the clk-domain snapshot q_sync and the wrap strobe tc.
`timescale 1ns/1ps
module async_down_counter_nbit #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [n-1:0] Q
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
  ,
  output logic [n-1:0] q_sync,
  output logic         tc
`endif
);
  for (genvar i = 0; i < n; i++) begin : g_stage
    logic s;
    if (i == 0) begin : g_lsb
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) s <= 1'b0;
        else if (en) s <= ~s;
    end else begin : g_rip
      // A rising lower bit means it borrowed, so this bit toggles.
      always_ff @(posedge Q[i-1] or negedge reset_n)
        if (!reset_n) s <= 1'b0;
        else s <= ~s;
    end
    assign Q[i] = s;
  end
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q_sync <= '0;
      tc     <= 1'b0;
    end else begin
      q_sync <= Q;
      tc     <= en && (Q == '0);
    end
`endif
endmodule

// File: tb/tb_async_down_counter_nbit.sv
// tb_async_down_counter_nbit: directed timeline checks of the 4-bit and 1-bit ripple down counter.
`timescale 1ns/1ps
module tb_async_down_counter_nbit;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] q4;
  logic [0:0] q1;
  int         vectors = 0;
  int         miscompares = 0;
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
  logic [3:0] qs4;
  logic [0:0] qs1;
  logic       tc4, tc1;
`endif

  async_down_counter_nbit #(.n(4)) d4 (
    .clk(clk), .reset_n(reset_n), .en(en), .Q(q4)
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
    , .q_sync(qs4), .tc(tc4)
`endif
  );

  async_down_counter_nbit #(.n(1)) d1 (
    .clk(clk), .reset_n(reset_n), .en(en), .Q(q1)
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
    , .q_sync(qs1), .tc(tc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d want %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  task automatic chk4(input string tag, input int q, input int qs, input int tc);
    chk({tag, ".Q"}, int'(q4), q);
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
    if (qs >= 0) chk({tag, ".q_sync"}, int'(qs4), qs);
    if (tc >= 0) chk({tag, ".tc"}, int'(tc4), tc);
`endif
  endtask

  task automatic chk1(input string tag, input int q, input int qs, input int tc);
    chk({tag, ".Q1"}, int'(q1), q);
`ifdef ASYNC_DOWN_COUNTER_SYNC_OUT_EN
    if (qs >= 0) chk({tag, ".q_sync1"}, int'(qs1), qs);
    if (tc >= 0) chk({tag, ".tc1"}, int'(tc1), tc);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    at(10);  chk4("reset", 0, 0, 0);   chk1("reset", 0, 0, 0);
    at(13);  reset_n = 1'b1;
    at(20);  chk4("wrap0", 15, 0, 1);  chk1("n1_e15", 1, 0, 1);
    at(30);  chk4("dec1", 14, 15, 0);  chk1("n1_e25", 0, 1, 0);
    at(40);  chk4("dec2", 13, 14, 0);  chk1("n1_e35", 1, 0, 1);
    at(170); chk4("zero", 0, 1, 0);
    at(180); chk4("wrap1", 15, 0, 1);
    at(190); chk4("post_wrap1", 14, 15, 0);
    at(340); chk4("wrap2", 15, 0, 1);
    at(350); chk4("post_wrap2", 14, 15, 0);
    at(352); reset_n = 1'b0;
    at(353); chk4("async_rst", 0, 0, 0);
    at(363); reset_n = 1'b1;
    at(370); chk4("restart", 15, 0, 1);
    at(400); chk4("pre_hold", 12, 13, 0);
    at(402); en = 1'b0;
    at(410); chk4("hold55", 12, 12, 0);
    at(420); chk4("hold65", 12, 12, 0);
    at(430); chk4("hold75", 12, 12, 0);
    at(432); en = 1'b1;
    at(440); chk4("resume", 11, 12, 0);
    at(470); chk4("pre_mid_rst", 8, 9, 0);
    at(471); reset_n = 1'b0;
    at(472); chk4("mid_rst", 0, 0, 0);
    at(473); reset_n = 1'b1;
    at(480); chk4("mid_restart", 15, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
